mem_access: RTL and testbench
=============================

# mem_access

Memory-access stage of the five-stage pipeline. It consumes the EX/MEM register outputs (write-back info, ALU op, memory address, store data). It runs loads and stores on a single-outstanding request/acknowledge data bus and drives the MEM/WB register inputs. While a bus transaction is outstanding it raises a stall request to the pipeline controller, and the controller then holds EX/MEM and bubbles MEM/WB.

## Interface
- TIMEOUT, 16: maximum number of cycles with `bus_req_o` high and no `bus_ack_i` before the access is aborted (range 2..255).
- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high (`ENABLE`)
- wrn_i  in  1  write-back enable from EX/MEM
- wrAddr_i  in  `RegAddrBus`  destination register
- result_i  in  `RegDataBus`  ALU result (non-memory ops)
- alu_op_i  in  `ALUOpBus`  operation; memory ops are `ALU_OP_LB/LBU/LH/LHU/LW/SB/SH/SW`
- mem_addr_i  in  `RegDataBus`  effective byte address
- mem_data_i  in  `RegDataBus`  store data, low-aligned
- bus_rdata_i  in  32  read data, valid when bus_ack_i=1
- bus_ack_i  in  1  transaction complete
- wrn_o  out  1  to MEM/WB
- wrAddr_o  out  `RegAddrBus`  to MEM/WB
- result_o  out  `RegDataBus`  to MEM/WB
- bus_req_o  out  1  request
- bus_we_o  out  1  1=store
- bus_addr_o  out  32  word address, i.e. {mem_addr_i[31:2],2'b00}
- bus_sel_o  out  4  byte lanes; bit3 = bits 31:24
- bus_wdata_o  out  32  store data, replicated per lane
- stallreq_o  out  1  to pipeline controller
- align_err_o  out  1  misaligned access, combinational
- bus_err_o  out  1  one-cycle pulse on timeout abort

## Operation
- FSM states:
  - IDLE: reset state.
  - WAIT: request outstanding.
  - DONE: result ready for one cycle.
- Registered state: the FSM state, a timeout counter (8 bits), a captured read word, and an error flag. All bus outputs and write-back outputs are combinational from this state and the inputs.
- Non-memory op in IDLE: outputs pass through (wrn_o=wrn_i, wrAddr_o=wrAddr_i, result_o=result_i). No request, stallreq_o=0.
- Memory op in IDLE:
  - bus_req_o=1 and stallreq_o=1.
  - If bus_ack_i=1 in the same cycle, the next state is DONE; otherwise WAIT.
- WAIT:
  - bus_req_o and the address, sel, we and wdata outputs are held from the EX/MEM inputs, which stay frozen by the stall.
  - stallreq_o=1.
  - On bus_ack_i, capture bus_rdata_i and go to DONE.
  - When the counter reaches TIMEOUT-1 without an ack, set the error flag and go to DONE.
- DONE:
  - bus_req_o=0 and stallreq_o=0.
  - Load: wrn_o=wrn_i, result_o = extended captured data.
  - Store: wrn_o=wrn_i and result_o=result_i.
  - Error: wrn_o=0 and bus_err_o=1.
  - Always returns to IDLE on the next edge.
- While in IDLE/WAIT with a memory op, wrn_o=0; MEM/WB is bubbled by the controller anyway.
- Lane selection is big-endian, using off=mem_addr_i[1:0]:
  - Byte: sel = 4'b1000 >> off.
  - Half: sel = 4'b1100 (off=0) or 4'b0011 (off=2).
  - Word: sel = 4'b1111.
- Store data: SB replicates {4{mem_data_i[7:0]}}, SH replicates {2{mem_data_i[15:0]}}, SW passes the word.
- Load extension: LB/LH sign-extend the selected lane, LBU/LHU zero-extend it, LW uses the full word.
- Misalignment is LH/LHU/SH with off[0]=1, or LW/SW with off≠0. In that case:
  - align_err_o=1.
  - No request is issued and stallreq_o=0.
  - wrn_o=0, and the FSM stays in IDLE.

## Timing
- Non-memory op: 0 added cycles (combinational through the stage).
- Memory op with ack arriving n cycles after the first request cycle (n≥0): stallreq_o is high for n+1 cycles, DONE follows for 1 cycle, and MEM/WB captures the result at the end of DONE. Minimum total is 2 cycles.
- The timeout counter clears in IDLE and increments on each WAIT cycle. An abort occurs after exactly TIMEOUT request cycles.
- An ack arriving in IDLE/WAIT on the same cycle as the counter limit is treated as success (ack wins).
- bus_ack_i outside an active request is ignored.
- Reset:
  - On the next edge, state=IDLE, the counter is 0, the captured word is 0 and the error flag is 0.
  - While rst=1, combinational outputs are forced to: wrn_o=`DISABLE`, wrAddr_o=0, result_o=`ZeroWord`, bus_req_o=0, bus_we_o=0, bus_sel_o=0, stallreq_o=0, bus_err_o=0, align_err_o=0.
  - A reset during WAIT drops the request without waiting for the ack.

## Test plan
- ADD-type op, result_i=0x1234, wrn_i=1, wrAddr_i=5 -> same cycle wrn_o=1, wrAddr_o=5, result_o=0x1234, stallreq_o=0, bus_req_o=0.
- LB at addr 0x103, ack after 2 wait cycles with rdata=0x000000F0 -> sel=4'b0001, stallreq_o high 3 cycles, then DONE: result_o=0xFFFFFFF0, wrn_o=1. Repeat with LBU -> result_o=0x000000F0.
- SH at addr 0x202, mem_data_i=0xABCD1234, zero-wait ack -> bus_addr_o=0x200, sel=4'b0011, we=1, wdata=0x12341234, stallreq_o high 1 cycle.
- LW at addr 0x101 -> align_err_o=1, bus_req_o=0, stallreq_o=0, wrn_o=0.
- LW with no ack, TIMEOUT=16 -> req high exactly 16 cycles, then DONE with bus_err_o=1 and wrn_o=0, then IDLE.
- Assert rst in the 3rd WAIT cycle of an LW -> next cycle bus_req_o=0 and stallreq_o=0. A late ack is ignored. After release, an LHU at 0x0 with rdata=0x8001xxxx gives result 0x00008001.

Source files
------------

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues loads/stores on a single-outstanding req/ack bus,
// stalls the pipeline while a request is open, and drives the MEM/WB register inputs.
module mem_access #(
    parameter int TIMEOUT    = 16,
    parameter int REG_ADDR_W = 5,
    parameter int ALU_OP_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wrn_i,
    input  logic [REG_ADDR_W-1:0] wrAddr_i,
    input  logic [31:0]           result_i,
    input  logic [ALU_OP_W-1:0]   alu_op_i,
    input  logic [31:0]           mem_addr_i,
    input  logic [31:0]           mem_data_i,
    input  logic [31:0]           bus_rdata_i,
    input  logic                  bus_ack_i,
    output logic                  wrn_o,
    output logic [REG_ADDR_W-1:0] wrAddr_o,
    output logic [31:0]           result_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [31:0]           bus_addr_o,
    output logic [3:0]            bus_sel_o,
    output logic [31:0]           bus_wdata_o,
    output logic                  stallreq_o,
    output logic                  align_err_o,
    output logic                  bus_err_o,
    output logic [1:0]            dbg_state_o
);
    localparam logic [ALU_OP_W-1:0] ALU_OP_LB  = ALU_OP_W'('h20);
    localparam logic [ALU_OP_W-1:0] ALU_OP_LBU = ALU_OP_W'('h21);
    localparam logic [ALU_OP_W-1:0] ALU_OP_LH  = ALU_OP_W'('h22);
    localparam logic [ALU_OP_W-1:0] ALU_OP_LHU = ALU_OP_W'('h23);
    localparam logic [ALU_OP_W-1:0] ALU_OP_LW  = ALU_OP_W'('h24);
    localparam logic [ALU_OP_W-1:0] ALU_OP_SB  = ALU_OP_W'('h28);
    localparam logic [ALU_OP_W-1:0] ALU_OP_SH  = ALU_OP_W'('h29);
    localparam logic [ALU_OP_W-1:0] ALU_OP_SW  = ALU_OP_W'('h2a);
    // The first request cycle happens in IDLE, so WAIT aborts one count early.
    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 2);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        is_byte, is_half, is_word, is_store, is_mem, is_signed;
    logic        misaligned, access;
    logic [1:0]  off;
    logic [3:0]  sel;
    logic [31:0] wdata, load_val;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        off        = mem_addr_i[1:0];
        is_byte    = (alu_op_i == ALU_OP_LB) || (alu_op_i == ALU_OP_LBU) || (alu_op_i == ALU_OP_SB);
        is_half    = (alu_op_i == ALU_OP_LH) || (alu_op_i == ALU_OP_LHU) || (alu_op_i == ALU_OP_SH);
        is_word    = (alu_op_i == ALU_OP_LW) || (alu_op_i == ALU_OP_SW);
        is_store   = (alu_op_i == ALU_OP_SB) || (alu_op_i == ALU_OP_SH) || (alu_op_i == ALU_OP_SW);
        is_signed  = (alu_op_i == ALU_OP_LB) || (alu_op_i == ALU_OP_LH);
        is_mem     = is_byte || is_half || is_word;
        misaligned = (is_half && off[0]) || (is_word && (off != 2'd0));
        access     = is_mem && !misaligned;

        sel   = 4'b0000;
        wdata = mem_data_i;
        if (is_byte) begin
            sel   = 4'b1000 >> off;
            wdata = {4{mem_data_i[7:0]}};
        end else if (is_half) begin
            sel   = off[1] ? 4'b0011 : 4'b1100;
            wdata = {2{mem_data_i[15:0]}};
        end else if (is_word) begin
            sel   = 4'b1111;
        end

        // Big-endian lanes: offset 0 lives in bits 31:24.
        case (off)
            2'd0:    ld_byte = rdata_q[31:24];
            2'd1:    ld_byte = rdata_q[23:16];
            2'd2:    ld_byte = rdata_q[15:8];
            default: ld_byte = rdata_q[7:0];
        endcase
        ld_half = off[1] ? rdata_q[15:0] : rdata_q[31:16];

        if (is_byte)      load_val = {{24{is_signed && ld_byte[7]}}, ld_byte};
        else if (is_half) load_val = {{16{is_signed && ld_half[15]}}, ld_half};
        else              load_val = rdata_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = 8'd0;
                err_d = 1'b0;
                if (access) begin
                    if (bus_ack_i) begin
                        rdata_d = bus_rdata_i;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (bus_ack_i) begin
                    rdata_d = bus_rdata_i;
                    state_d = S_DONE;
                end else if (cnt_q == LIMIT) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
                err_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        wrn_o       = 1'b0;
        wrAddr_o    = '0;
        result_o    = 32'd0;
        bus_req_o   = 1'b0;
        bus_we_o    = 1'b0;
        bus_sel_o   = 4'b0000;
        stallreq_o  = 1'b0;
        align_err_o = 1'b0;
        bus_err_o   = 1'b0;
        bus_addr_o  = {mem_addr_i[31:2], 2'b00};
        bus_wdata_o = wdata;
        dbg_state_o = state_q;
        if (!rst) begin
            wrAddr_o    = wrAddr_i;
            result_o    = result_i;
            align_err_o = is_mem && misaligned;
            case (state_q)
                S_IDLE: begin
                    if (!is_mem) begin
                        wrn_o = wrn_i;
                    end else if (access) begin
                        bus_req_o  = 1'b1;
                        bus_we_o   = is_store;
                        bus_sel_o  = sel;
                        stallreq_o = 1'b1;
                    end
                end
                S_WAIT: begin
                    bus_req_o  = 1'b1;
                    bus_we_o   = is_store;
                    bus_sel_o  = sel;
                    stallreq_o = 1'b1;
                end
                default: begin
                    if (err_q) begin
                        bus_err_o = 1'b1;
                    end else begin
                        wrn_o = wrn_i;
                        if (!is_store) result_o = load_val;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: expected results go into a queue when an access is
// issued and are popped when the stage reaches its DONE cycle.
module tb_mem_access;
    localparam logic [7:0] OP_ADD = 8'h01;
    localparam logic [7:0] OP_LB  = 8'h20;
    localparam logic [7:0] OP_LBU = 8'h21;
    localparam logic [7:0] OP_LH  = 8'h22;
    localparam logic [7:0] OP_LHU = 8'h23;
    localparam logic [7:0] OP_LW  = 8'h24;
    localparam logic [7:0] OP_SB  = 8'h28;
    localparam logic [7:0] OP_SH  = 8'h29;

    logic        clk = 1'b0;
    logic        rst;
    logic        wrn_i;
    logic [4:0]  wrAddr_i;
    logic [31:0] result_i, mem_addr_i, mem_data_i, bus_rdata_i;
    logic [7:0]  alu_op_i;
    logic        bus_ack_i;
    logic        wrn_o, bus_req_o, bus_we_o, stallreq_o, align_err_o, bus_err_o;
    logic [4:0]  wrAddr_o;
    logic [31:0] result_o, bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_sel_o;
    logic [1:0]  dbg_state_o;

    logic [31:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    mem_access #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .wrn_i(wrn_i), .wrAddr_i(wrAddr_i), .result_i(result_i),
        .alu_op_i(alu_op_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
        .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i), .wrn_o(wrn_o), .wrAddr_o(wrAddr_o),
        .result_o(result_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o), .stallreq_o(stallreq_o),
        .align_err_o(align_err_o), .bus_err_o(bus_err_o), .dbg_state_o(dbg_state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input logic wrn, input logic [4:0] wra, input logic [31:0] res);
        alu_op_i   = op;
        mem_addr_i = addr;
        mem_data_i = data;
        wrn_i      = wrn;
        wrAddr_i   = wra;
        result_i   = res;
    endtask

    task automatic nop();
        drive(OP_ADD, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        bus_ack_i = 1'b0;
    endtask

    // Issue one memory access acked after n_wait wait cycles; checks the bus side each
    // request cycle and the write-back side in DONE against the queued expectation.
    task automatic run_mem(input string tag, input logic [7:0] op, input logic [31:0] addr,
                           input logic [31:0] data, input logic wrn, input logic [31:0] res,
                           input int n_wait, input logic [31:0] rdata, input logic [3:0] exp_sel,
                           input logic exp_we, input logic [31:0] exp_wdata, input logic [31:0] exp_res);
        int stall_cycles;
        logic [31:0] exp;
        stall_cycles = 0;
        drive(op, addr, data, wrn, 5'd9, res);
        bus_rdata_i = rdata;
        bus_ack_i   = (n_wait == 0);
        exp_q.push_back(exp_res);
        #1;
        chk({tag, "_sel"}, {28'd0, bus_sel_o}, {28'd0, exp_sel});
        chk({tag, "_we"}, {31'd0, bus_we_o}, {31'd0, exp_we});
        chk({tag, "_addr"}, bus_addr_o, {addr[31:2], 2'b00});
        if (exp_we) chk({tag, "_wdata"}, bus_wdata_o, exp_wdata);
        for (int i = 0; i <= n_wait && i < 40; i++) begin
            if (i > 0) begin
                tick();
                bus_ack_i = (i == n_wait);
                #1;
            end
            chk({tag, "_req"}, {31'd0, bus_req_o}, 32'd1);
            if (stallreq_o) stall_cycles++;
        end
        tick();
        bus_ack_i = 1'b0;
        #1;
        chk({tag, "_stall_cycles"}, stall_cycles, n_wait + 1);
        chk({tag, "_done_stall"}, {31'd0, stallreq_o}, 32'd0);
        chk({tag, "_done_req"}, {31'd0, bus_req_o}, 32'd0);
        chk({tag, "_done_wrn"}, {31'd0, wrn_o}, {31'd0, wrn});
        chk({tag, "_q_size"}, exp_q.size(), 32'd1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
        chk({tag, "_result"}, result_o, exp);
        tick();
        nop();
        #1;
        chk({tag, "_back_idle"}, {30'd0, dbg_state_o}, 32'd0);
    endtask

    initial begin
        int req_cycles;
        rst = 1'b1;
        bus_rdata_i = 32'h0;
        bus_ack_i = 1'b0;
        drive(OP_LW, 32'h100, 32'h0, 1'b1, 5'd3, 32'h77);
        tick();
        tick();
        #1;
        chk("rst_req", {31'd0, bus_req_o}, 32'd0);
        chk("rst_stall", {31'd0, stallreq_o}, 32'd0);
        chk("rst_wrn", {31'd0, wrn_o}, 32'd0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_state", {30'd0, dbg_state_o}, 32'd0);

        rst = 1'b0;
        drive(OP_ADD, 32'h0, 32'h0, 1'b1, 5'd5, 32'h1234);
        #1;
        chk("add_wrn", {31'd0, wrn_o}, 32'd1);
        chk("add_wraddr", {27'd0, wrAddr_o}, 32'd5);
        chk("add_result", result_o, 32'h1234);
        chk("add_stall", {31'd0, stallreq_o}, 32'd0);
        chk("add_req", {31'd0, bus_req_o}, 32'd0);
        tick();

        run_mem("lb", OP_LB, 32'h103, 32'h0, 1'b1, 32'h0, 2, 32'h000000F0, 4'b0001, 1'b0, 32'h0, 32'hFFFFFFF0);
        run_mem("lbu", OP_LBU, 32'h103, 32'h0, 1'b1, 32'h0, 2, 32'h000000F0, 4'b0001, 1'b0, 32'h0, 32'h000000F0);
        run_mem("sh", OP_SH, 32'h202, 32'hABCD1234, 1'b0, 32'h55, 0, 32'h0, 4'b0011, 1'b1, 32'h12341234, 32'h55);
        run_mem("sb", OP_SB, 32'h001, 32'h00000077, 1'b0, 32'h66, 1, 32'h0, 4'b0100, 1'b1, 32'h77777777, 32'h66);
        run_mem("lh", OP_LH, 32'h002, 32'h0, 1'b1, 32'h0, 1, 32'h12348765, 4'b0011, 1'b0, 32'h0, 32'hFFFF8765);
        run_mem("lw", OP_LW, 32'h010, 32'h0, 1'b1, 32'h0, 3, 32'hDEADBEEF, 4'b1111, 1'b0, 32'h0, 32'hDEADBEEF);

        drive(OP_LW, 32'h101, 32'h0, 1'b1, 5'd4, 32'h0);
        #1;
        chk("mis_align_err", {31'd0, align_err_o}, 32'd1);
        chk("mis_req", {31'd0, bus_req_o}, 32'd0);
        chk("mis_stall", {31'd0, stallreq_o}, 32'd0);
        chk("mis_wrn", {31'd0, wrn_o}, 32'd0);
        tick();
        chk("mis_state", {30'd0, dbg_state_o}, 32'd0);
        nop();
        tick();

        drive(OP_LW, 32'h300, 32'h0, 1'b1, 5'd6, 32'h0);
        #1;
        req_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (!bus_req_o) break;
            req_cycles++;
            tick();
            #1;
        end
        chk("to_req_cycles", req_cycles, 32'd16);
        chk("to_bus_err", {31'd0, bus_err_o}, 32'd1);
        chk("to_wrn", {31'd0, wrn_o}, 32'd0);
        chk("to_state_done", {30'd0, dbg_state_o}, 32'd2);
        tick();
        nop();
        #1;
        chk("to_state_idle", {30'd0, dbg_state_o}, 32'd0);
        chk("to_err_clear", {31'd0, bus_err_o}, 32'd0);
        tick();

        drive(OP_LW, 32'h400, 32'h0, 1'b1, 5'd7, 32'h0);
        tick();
        tick();
        tick();
        chk("rw_in_wait", {30'd0, dbg_state_o}, 32'd1);
        rst = 1'b1;
        tick();
        #1;
        chk("rw_req", {31'd0, bus_req_o}, 32'd0);
        chk("rw_stall", {31'd0, stallreq_o}, 32'd0);
        chk("rw_state", {30'd0, dbg_state_o}, 32'd0);
        rst = 1'b0;
        nop();
        bus_ack_i = 1'b1;
        bus_rdata_i = 32'hCAFEF00D;
        #1;
        chk("late_ack_req", {31'd0, bus_req_o}, 32'd0);
        tick();
        bus_ack_i = 1'b0;
        #1;
        chk("late_ack_state", {30'd0, dbg_state_o}, 32'd0);
        run_mem("lhu", OP_LHU, 32'h0, 32'h0, 1'b1, 32'h0, 0, 32'h80015A5A, 4'b1100, 1'b0, 32'h0, 32'h00008001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
